// File: rtl/rgb_fade_pkg.sv
// Shared types and constants for the RGB fade sequencer.
package rgb_fade_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD      = 3'd2,
        RAMP_DOWN = 3'd3,
        GAP       = 3'd4
    } fade_state_e;

    localparam logic [1:0] COL_RED   = 2'd0;
    localparam logic [1:0] COL_GREEN = 2'd1;
    localparam logic [1:0] COL_BLUE  = 2'd2;

    // Largest duty / counter value for a given PWM width.
    function automatic int unsigned pwm_max(input int unsigned bits);
        return (32'(1) << bits) - 32'(1);
    endfunction

endpackage

// File: rtl/fade_pwm_core.sv
// Free-running PWM counter with period-aligned shadow duty and registered compare.
module fade_pwm_core
    import rgb_fade_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                force_off,
    output logic                pwm_raw
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'(pwm_max(PWM_BITS));

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] shadow;

    // Counter wraps naturally at CNT_MAX; shadow only reloads at the period boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            shadow  <= '0;
            pwm_raw <= 1'b0;
        end else begin
            cnt     <= cnt + PWM_BITS'(1);
            if (cnt == CNT_MAX) begin
                shadow <= duty;
            end
            pwm_raw <= !force_off && (cnt < shadow);
        end
    end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// One-colour-at-a-time fade sequencer (red, green, blue) driving RGB PWM enables.
module rgb_fade_sequencer
    import rgb_fade_pkg::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned PRESCALE   = 32768,
    parameter int unsigned STEP       = 8,
    parameter int unsigned HOLD_TICKS = 16
) (
    input  logic                hw_clk,
    input  logic                reset,
    input  logic                enable,
    output logic                pwm_red,
    output logic                pwm_green,
    output logic                pwm_blue,
    output logic [1:0]          colour_sel,
    output logic [PWM_BITS-1:0] duty_level,
    output logic                cycle_done
);

    localparam int unsigned PRE_W  = $clog2(PRESCALE);
    localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int unsigned DX_W   = PWM_BITS + 1;

    localparam logic [PWM_BITS-1:0] DUTY_MAX  = PWM_BITS'(pwm_max(PWM_BITS));
    localparam logic [DX_W-1:0]     DUTY_MAXX = DX_W'(pwm_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] STEP_V    = PWM_BITS'(STEP);
    localparam logic [DX_W-1:0]     STEP_X    = DX_W'(STEP);
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    fade_state_e         state;
    fade_state_e         state_next;
    logic [1:0]          colour_next;
    logic [PWM_BITS-1:0] duty_next;
    logic [PRE_W-1:0]    presc;
    logic [PRE_W-1:0]    presc_next;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_next;
    logic                done_next;

    logic                tick;
    logic [DX_W-1:0]     sum_x;
    logic [PWM_BITS-1:0] up_duty;
    logic [PWM_BITS-1:0] down_duty;
    logic                force_off;
    logic                pwm_raw;

    // Fade tick and saturating duty arithmetic.
    always_comb begin
        tick      = (presc == PRE_LAST);
        sum_x     = {1'b0, duty_level} + STEP_X;
        up_duty   = (sum_x > DUTY_MAXX) ? DUTY_MAX : sum_x[PWM_BITS-1:0];
        down_duty = (duty_level > STEP_V) ? (duty_level - STEP_V) : '0;
    end

    // Sequencer next-state and registered-output next values.
    always_comb begin
        state_next  = state;
        colour_next = colour_sel;
        duty_next   = duty_level;
        presc_next  = presc;
        hold_next   = hold_cnt;
        done_next   = 1'b0;

        if (state != IDLE) begin
            presc_next = tick ? '0 : (presc + PRE_W'(1));
        end

        case (state)
            IDLE: begin
                presc_next = '0;
                duty_next  = '0;
                if (enable) begin
                    state_next = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (tick) begin
                    duty_next = up_duty;
                    if (up_duty == DUTY_MAX) begin
                        state_next = HOLD;
                        hold_next  = '0;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_next = RAMP_DOWN;
                    end else begin
                        hold_next = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            RAMP_DOWN: begin
                if (tick) begin
                    duty_next = down_duty;
                    if (down_duty == '0) begin
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                duty_next = '0;
                if (tick) begin
                    state_next  = RAMP_UP;
                    colour_next = (colour_sel == COL_BLUE) ? COL_RED : (colour_sel + 2'd1);
                    done_next   = (colour_sel == COL_BLUE);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Disable overrides everything, including a coincident tick.
        if ((state != IDLE) && !enable) begin
            state_next  = IDLE;
            colour_next = colour_sel;
            duty_next   = '0;
            presc_next  = '0;
            hold_next   = '0;
            done_next   = 1'b0;
        end
    end

    // Sequencer state and status registers.
    always_ff @(posedge hw_clk) begin
        if (reset) begin
            state      <= IDLE;
            colour_sel <= COL_RED;
            duty_level <= '0;
            presc      <= '0;
            hold_cnt   <= '0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_next;
            colour_sel <= colour_next;
            duty_level <= duty_next;
            presc      <= presc_next;
            hold_cnt   <= hold_next;
            cycle_done <= done_next;
        end
    end

    // Blank the compare register in the same edge that enters IDLE.
    assign force_off = (state_next == IDLE);

    fade_pwm_core #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_core (
        .clk       (hw_clk),
        .reset     (reset),
        .duty      (duty_level),
        .force_off (force_off),
        .pwm_raw   (pwm_raw)
    );

    // Steering is a decode of registered signals only, so it cannot glitch.
    assign pwm_red   = pwm_raw && (colour_sel == COL_RED);
    assign pwm_green = pwm_raw && (colour_sel == COL_GREEN);
    assign pwm_blue  = pwm_raw && (colour_sel == COL_BLUE);

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer against a fade-profile reference model.
module tb_rgb_fade_sequencer;

    localparam int unsigned PWM_BITS   = 8;
    localparam int unsigned PRESCALE   = 4;
    localparam int unsigned STEP       = 64;
    localparam int unsigned HOLD_TICKS = 2;
    localparam int unsigned PWM_MAX    = (1 << PWM_BITS) - 1;

    logic                hw_clk = 1'b0;
    logic                reset  = 1'b1;
    logic                enable = 1'b0;
    logic                pwm_red;
    logic                pwm_green;
    logic                pwm_blue;
    logic [1:0]          colour_sel;
    logic [PWM_BITS-1:0] duty_level;
    logic                cycle_done;

    int unsigned passed = 0;
    int unsigned checks = 0;

    // Reference model: duty per tick index within one colour, plus PWM period model.
    int unsigned profile[$];
    bit          m_run;
    int unsigned m_pre;
    int          m_k;
    int unsigned m_col;
    int unsigned m_cnt;
    int unsigned m_shadow;
    bit          m_raw;
    bit          m_done;

    rgb_fade_sequencer #(
        .PWM_BITS   (PWM_BITS),
        .PRESCALE   (PRESCALE),
        .STEP       (STEP),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .hw_clk     (hw_clk),
        .reset      (reset),
        .enable     (enable),
        .pwm_red    (pwm_red),
        .pwm_green  (pwm_green),
        .pwm_blue   (pwm_blue),
        .colour_sel (colour_sel),
        .duty_level (duty_level),
        .cycle_done (cycle_done)
    );

    always #5 hw_clk = ~hw_clk;

    function automatic int unsigned exp_duty();
        return m_run ? profile[m_k] : 0;
    endfunction

    task automatic build_profile();
        int unsigned d;
        d = 0;
        profile.delete();
        profile.push_back(0);
        while (d < PWM_MAX) begin
            d = (d + STEP > PWM_MAX) ? PWM_MAX : d + STEP;
            profile.push_back(d);
        end
        repeat (HOLD_TICKS) profile.push_back(PWM_MAX);
        while (d > 0) begin
            d = (d > STEP) ? d - STEP : 0;
            profile.push_back(d);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pre = 0; m_k = 0; m_col = 0;
        m_cnt = 0; m_shadow = 0; m_raw = 0; m_done = 0;
    endtask

    task automatic model_edge();
        int unsigned dbefore;
        bit          rnext;
        dbefore = exp_duty();
        if (reset) begin
            model_reset();
        end else begin
            rnext = (m_cnt < m_shadow);
            if (m_cnt == PWM_MAX) m_shadow = dbefore;
            m_cnt  = (m_cnt == PWM_MAX) ? 0 : m_cnt + 1;
            m_done = 0;
            if (!m_run) begin
                if (enable) begin
                    m_run = 1; m_pre = 0; m_k = 0;
                end
            end else if (!enable) begin
                m_run = 0; m_pre = 0; m_k = 0;
            end else if (m_pre == PRESCALE - 1) begin
                m_pre = 0;
                m_k++;
                if (m_k == profile.size()) begin
                    m_k    = 0;
                    m_done = (m_col == 2);
                    m_col  = (m_col + 1) % 3;
                end
            end else begin
                m_pre++;
            end
            m_raw = m_run && rnext;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) passed++;
        else $error("FAIL %s: got %0d want %0d", tag, obs, want);
    endtask

    task automatic check_outputs();
        chk("duty_level", 32'(duty_level), 32'(exp_duty()));
        chk("colour_sel", 32'(colour_sel), 32'(m_col));
        chk("pwm_red",    32'(pwm_red),    32'(m_raw && (m_col == 0)));
        chk("pwm_green",  32'(pwm_green),  32'(m_raw && (m_col == 1)));
        chk("pwm_blue",   32'(pwm_blue),   32'(m_raw && (m_col == 2)));
        chk("cycle_done", 32'(cycle_done), 32'(m_done));
    endtask

    task automatic cycle();
        @(posedge hw_clk);
        model_edge();
        @(negedge hw_clk);
        check_outputs();
    endtask

    task automatic period_check(input string tag);
        bit          found;
        int unsigned hi;
        int unsigned ld;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycle();
            if (m_cnt == 0) found = 1;
        end
        if (!found) begin
            chk({tag, "_timeout"}, 32'(0), 32'(1));
        end else begin
            ld = m_shadow;
            hi = 0;
            for (int i = 0; i < 256; i++) begin
                cycle();
                if (pwm_red || pwm_green || pwm_blue) hi++;
            end
            chk(tag, 32'(hi), 32'(ld));
        end
    endtask

    initial begin
        int unsigned seq[10];
        int unsigned pulses;
        bit          found;
        seq = '{64, 128, 192, 255, 255, 255, 191, 127, 63, 0};

        build_profile();
        model_reset();

        // Reset held 3 cycles, then idle with enable low.
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) cycle();
        chk("rst_duty",   32'(duty_level), 32'(0));
        chk("rst_colour", 32'(colour_sel), 32'(0));
        chk("rst_pwm",    32'({pwm_red, pwm_green, pwm_blue}), 32'(0));
        chk("rst_done",   32'(cycle_done), 32'(0));
        reset = 1'b0;
        repeat (20) cycle();
        chk("idle_duty", 32'(duty_level), 32'(0));

        // Red ramp sequence with clamping, hold, ramp down, gap.
        enable = 1'b1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            repeat (PRESCALE) cycle();
            chk("ramp_seq", 32'(duty_level), 32'(seq[i]));
        end
        repeat (PRESCALE) cycle();
        chk("green_after_gap", 32'(colour_sel), 32'(1));
        chk("no_done_r2g",     32'(cycle_done), 32'(0));

        // Exactly one cycle_done pulse, on blue -> red.
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (cycle_done) begin
                pulses++;
                chk("done_colour", 32'(colour_sel), 32'(0));
            end
        end
        chk("done_pulses", 32'(pulses), 32'(1));

        // High-cycle count per PWM period equals the duty latched at period start.
        period_check("period_a");
        period_check("period_b");

        // Disable during green HOLD, then re-enable.
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            cycle();
            if (m_run && m_col == 1 && m_k == 5) found = 1;
        end
        chk("green_hold_found", 32'(found), 32'(1));
        enable = 1'b0;
        cycle();
        chk("dis_pwm",    32'({pwm_red, pwm_green, pwm_blue}), 32'(0));
        chk("dis_duty",   32'(duty_level), 32'(0));
        chk("dis_colour", 32'(colour_sel), 32'(1));
        repeat (5) cycle();
        enable = 1'b1;
        cycle();
        repeat (PRESCALE) cycle();
        chk("reen_duty",   32'(duty_level), 32'(64));
        chk("reen_colour", 32'(colour_sel), 32'(1));

        // Reset during blue RAMP_DOWN at duty 127.
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            cycle();
            if (m_run && m_col == 2 && exp_duty() == 127) found = 1;
        end
        chk("blue_down_found", 32'(found), 32'(1));
        chk("blue_down_duty",  32'(duty_level), 32'(127));
        reset = 1'b1;
        cycle();
        chk("mid_rst_duty",   32'(duty_level), 32'(0));
        chk("mid_rst_colour", 32'(colour_sel), 32'(0));
        chk("mid_rst_pwm",    32'({pwm_red, pwm_green, pwm_blue}), 32'(0));
        chk("mid_rst_done",   32'(cycle_done), 32'(0));
        reset = 1'b0;
        cycle();
        repeat (PRESCALE) cycle();
        chk("restart_duty",   32'(duty_level), 32'(64));
        chk("restart_colour", 32'(colour_sel), 32'(0));

        // Randomised enable toggling with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (enable) begin
                if ($urandom_range(127) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(7) == 0) enable = 1'b1;
            end
            reset = ($urandom_range(499) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
